// File: rtl/blink_receiver.sv
// Receive side of the LED blink link: synchronizes and debounces the blink line,
// measures its half-period in clk cycles and declares lock once the period is stable.
module blink_receiver #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HALF    = 4,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             blink_in,
  output logic             level,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int STABLE_W = (MIN_HALF > 1) ? $clog2(MIN_HALF) : 1;
  localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(MIN_HALF - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LOCK  = MATCH_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [CNT_W:0]      TOL_V       = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic [STABLE_W-1:0]     stable_cnt_reg;
  logic [CNT_W-1:0]        period_cnt_reg;
  logic [CNT_W-1:0]        prev_reg;
  logic                    have_prev_reg;
  logic [MATCH_W-1:0]      match_cnt_reg;

  logic                    synced;
  logic                    differ;
  logic                    accept;
  logic                    saturated;
  logic [CNT_W-1:0]        meas;
  logic [CNT_W:0]          abs_diff;
  logic                    close;
  logic [MATCH_W-1:0]      match_inc;

  always_comb begin
    synced    = sync_reg[SYNC_STAGES-1];
    differ    = (synced != level);
    accept    = differ && (stable_cnt_reg == STABLE_LAST);
    saturated = (period_cnt_reg == CNT_MAX);
    // meas is only consumed when not saturated, so the +1 cannot wrap there
    meas      = period_cnt_reg + 1'b1;
    abs_diff  = (meas >= prev_reg) ? ({1'b0, meas} - {1'b0, prev_reg})
                                   : ({1'b0, prev_reg} - {1'b0, meas});
    close     = have_prev_reg && (abs_diff <= TOL_V);
    match_inc = match_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg       <= '0;
      stable_cnt_reg <= '0;
      period_cnt_reg <= '0;
      prev_reg       <= '0;
      have_prev_reg  <= 1'b0;
      match_cnt_reg  <= '0;
      state_reg      <= IDLE;
      level          <= 1'b0;
      half_period    <= '0;
      period_valid   <= 1'b0;
      locked         <= 1'b0;
      timeout        <= 1'b0;
    end else if (!ena) begin
      sync_reg       <= '0;
      stable_cnt_reg <= '0;
      period_cnt_reg <= '0;
      prev_reg       <= '0;
      have_prev_reg  <= 1'b0;
      match_cnt_reg  <= '0;
      state_reg      <= IDLE;
      level          <= 1'b0;
      half_period    <= '0;
      period_valid   <= 1'b0;
      locked         <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], blink_in};
      period_valid <= 1'b0;

      if (!differ || accept) begin
        stable_cnt_reg <= '0;
      end else begin
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
      end

      if (accept) begin
        level          <= synced;
        period_cnt_reg <= '0;
      end else if (!saturated) begin
        period_cnt_reg <= period_cnt_reg + 1'b1;
      end

      if (accept && saturated) begin
        // Edge after a gap too long to measure: restart from a fresh baseline
        state_reg     <= ACQ;
        have_prev_reg <= 1'b0;
        match_cnt_reg <= '0;
        locked        <= 1'b0;
        timeout       <= 1'b0;
      end else if (saturated) begin
        state_reg     <= IDLE;
        have_prev_reg <= 1'b0;
        match_cnt_reg <= '0;
        locked        <= 1'b0;
        timeout       <= 1'b1;
      end else if (accept) begin
        timeout <= 1'b0;
        case (state_reg)
          IDLE: begin
            state_reg     <= ACQ;
            have_prev_reg <= 1'b0;
            match_cnt_reg <= '0;
          end
          ACQ: begin
            period_valid  <= 1'b1;
            half_period   <= meas;
            prev_reg      <= meas;
            have_prev_reg <= 1'b1;
            if (!close) begin
              match_cnt_reg <= '0;
            end else if (match_inc == MATCH_LOCK) begin
              state_reg     <= LOCKED;
              locked        <= 1'b1;
              match_cnt_reg <= '0;
            end else begin
              match_cnt_reg <= match_inc;
            end
          end
          LOCKED: begin
            period_valid <= 1'b1;
            half_period  <= meas;
            // While locked the reference stays put, so slow drift cannot walk it away
            if (!close) begin
              state_reg     <= ACQ;
              locked        <= 1'b0;
              match_cnt_reg <= '0;
              prev_reg      <= meas;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_receiver.sv
// Bench for blink_receiver: drives square waves with known half lengths and checks
// each accepted edge against an edge-level model of measurement and lock rules.
module tb_blink_receiver;

  localparam int CNT_W      = 16;
  localparam int MIN_HALF   = 4;
  localparam int TOL        = 2;
  localparam int LOCK_COUNT = 3;
  localparam int LAT        = 2 + MIN_HALF;
  localparam int MAXC       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             blink_in;
  logic             level;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  int checks   = 0;
  int failures = 0;

  // Edge-level reference model
  bit   mdl_active;
  bit   mdl_have_prev;
  bit   mdl_locked;
  int   mdl_prev;
  int   mdl_matches;
  bit   exp_strobe;
  bit   exp_timeout;
  logic exp_level;
  int   exp_half;
  int   gap;

  blink_receiver #(
    .CNT_W(CNT_W), .SYNC_STAGES(2), .MIN_HALF(MIN_HALF), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .blink_in(blink_in),
    .level(level),
    .half_period(half_period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_half"}, half_period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic model_reset();
    mdl_active    = 1'b0;
    mdl_have_prev = 1'b0;
    mdl_locked    = 1'b0;
    mdl_prev      = 0;
    mdl_matches   = 0;
    exp_strobe    = 1'b0;
    exp_timeout   = 1'b0;
    exp_level     = 1'b0;
    exp_half      = 0;
    gap           = 0;
  endtask

  // g = clean cycles between this edge and the previous driven edge
  task automatic model_edge(input int g, input logic v);
    int d;
    bit close;
    exp_level   = v;
    exp_timeout = 1'b0;
    if (!mdl_active || g > MAXC) begin
      mdl_active    = 1'b1;
      mdl_have_prev = 1'b0;
      mdl_matches   = 0;
      mdl_locked    = 1'b0;
      exp_strobe    = 1'b0;
    end else begin
      exp_strobe = 1'b1;
      exp_half   = g;
      d = (g > mdl_prev) ? g - mdl_prev : mdl_prev - g;
      close = mdl_have_prev && (d <= TOL);
      if (mdl_locked) begin
        if (!close) begin
          mdl_locked  = 1'b0;
          mdl_matches = 0;
          mdl_prev    = g;
        end
      end else begin
        mdl_matches   = close ? mdl_matches + 1 : 0;
        mdl_prev      = g;
        mdl_have_prev = 1'b1;
        if (mdl_matches >= LOCK_COUNT) begin
          mdl_locked  = 1'b1;
          mdl_matches = 0;
        end
      end
    end
  endtask

  // Toggle the line and hold it for len cycles, optionally with a 3-cycle glitch
  task automatic drive_half(input int len, input int glitch_at);
    int   strobes;
    logic old_level;
    old_level = exp_level;
    strobes   = 0;
    blink_in  = ~blink_in;
    model_edge(gap, blink_in);
    gap = 0;
    for (int i = 1; i <= len; i++) begin
      @(posedge clk);
      @(negedge clk);
      gap++;
      if (period_valid === 1'b1) strobes++;
      if (glitch_at > 0 && (i == glitch_at || i == glitch_at + 3)) blink_in = ~blink_in;
      if (i == LAT - 1) check("level_before_accept", level, old_level);
      if (i == LAT) begin
        check("level_after_accept", level, exp_level);
        check("period_valid", period_valid, exp_strobe);
        check("half_period", half_period, exp_half);
        check("locked", locked, mdl_locked);
        check("timeout", timeout, exp_timeout);
      end
    end
    check("strobes_per_half", strobes, exp_strobe);
    $display("half len=%0d glitch=%0d line=%0b strobe=%0b half_period=%0d locked=%0b",
             len, glitch_at, blink_in, exp_strobe, half_period, locked);
  endtask

  initial begin
    int base;
    int len;
    int glitch;
    int strobes;

    rst      = 1'b1;
    ena      = 1'b1;
    blink_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Steady 512-cycle halves: lock arrives with the fourth strobe
    for (int k = 0; k < 6; k++) drive_half(512, 0);
    check("lock_512", locked, 1);

    // Jitter within tolerance of the locked reference, then a real change
    drive_half(513, 0);
    drive_half(511, 0);
    drive_half(514, 0);
    drive_half(520, 0);
    drive_half(512, 0);
    check("jump_unlock", locked, 0);
    check("jump_half", half_period, 520);

    // Relock, then a short glitch inside a half must not disturb the measurement
    for (int k = 0; k < 5; k++) drive_half(512, 0);
    drive_half(512, 200);
    drive_half(512, 0);
    check("glitch_half", half_period, 512);
    check("glitch_locked", locked, 1);

    // Asynchronous reset while locked
    if (blink_in) drive_half(512, 0);
    #2 rst = 1'b1;
    #1 check_cleared("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("async reset pulse applied while locked");

    // Relock needs four strobes (five edges)
    for (int k = 0; k < 4; k++) drive_half(300, 0);
    check("relock_not_yet", locked, 0);
    drive_half(300, 0);
    check("relock_done", locked, 1);

    // One-cycle enable drop clears like reset
    if (blink_in) drive_half(300, 0);
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_cleared("ena_clear");
    ena = 1'b1;
    model_reset();
    $display("ena dropped for one cycle");

    // Randomized halves around drifting bases, with occasional glitches
    for (int r = 0; r < 24; r++) begin
      if (r % 8 == 0) base = int'($urandom_range(30, 250));
      len = base + int'($urandom_range(0, 2 * TOL + 2)) - (TOL + 1);
      glitch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, len - 10)) : 0;
      drive_half(len, glitch);
    end

    // Square wave with half=3 is below the debounce length: nothing accepted, then timeout
    if (blink_in) drive_half(100, 0);
    strobes = 0;
    for (int i = 0; i < 65600; i++) begin
      @(posedge clk);
      @(negedge clk);
      gap++;
      if (period_valid === 1'b1) strobes++;
      if (i % 3 == 2) blink_in = ~blink_in;
    end
    blink_in = exp_level;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      gap++;
      if (period_valid === 1'b1) strobes++;
    end
    check("fast_no_strobe", strobes, 0);
    check("fast_level", level, exp_level);
    check("fast_timeout", timeout, 1);
    check("fast_locked", locked, 0);
    $display("half=3 wave for 65600 cycles strobes=%0d timeout=%0b", strobes, timeout);

    // First edge after timeout is a baseline, the next one measures
    drive_half(100, 0);
    drive_half(100, 0);
    drive_half(100, 0);
    check("post_timeout_half", half_period, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
